atomic_sequencer: RTL and testbench
===================================

ATOMIC_SEQUENCER -- requirements
Module: atomic_sequencer

Interface
REQ-001 SHALL have parameters TL_DW default 32 (data bits), TL_AW default 32 (address bits), TL_SW default 4 (source-ID bits).
REQ-002 SHALL have tilelink_clock_i  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have tilelink_reset_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have a_valid/a_ready  in/out  1 each  upstream A handshake.
REQ-005 SHALL have a_opcode  in  3  2=ArithmeticData, 3=LogicalData; other values are never presented.
REQ-006 SHALL have a_param  in  3  atomic sub-operation.
REQ-007 SHALL have a_size, a_source, a_address, a_data  in  3/TL_SW/TL_AW/TL_DW  request fields; a_size always log2(TL_DW/8).
REQ-008 SHALL have d_valid/d_ready  out/in  1 each  upstream D handshake.
REQ-009 SHALL have d_opcode, d_size, d_source  out  3/3/TL_SW  response header; d_opcode fixed at 1 (AccessAckData).
REQ-010 SHALL have d_data, d_denied  out  TL_DW/1  pre-operation memory value, error flag.
REQ-011 SHALL have ma_valid/ma_ready  out/in  1 each  memory-side A handshake.
REQ-012 SHALL have ma_opcode, ma_size, ma_address, ma_data  out  3/3/TL_AW/TL_DW  4=Get, 0=PutFullData; mask implied full-word.
REQ-013 SHALL have md_valid/md_ready  in/out  1 each  memory-side D handshake.
REQ-014 SHALL have md_data, md_denied  in  TL_DW/1  memory response data, error flag.

Function
REQ-015 SHALL be a one-outstanding FSM: IDLE, GET, GWAIT, PUT, PWAIT, RESP.
REQ-016 IDLE: a_ready=1; on a_valid&a_ready SHALL register opcode, param, size, source, address, data and go to GET; a_ready=0 in all other states.
REQ-017 GET: ma_valid=1, ma_opcode=4, ma_data=0; held stable until ma_ready; then GWAIT.
REQ-018 GWAIT: md_ready=1; on md_valid SHALL register md_data as old value, register the atomalu result, and go to PUT, or to RESP with denied=1 when md_denied.
REQ-019 Result SHALL match atomalu (operands: registered a_data, md_data): opcode 3 -> param 0 XOR, 1 OR, 2 AND, 3 SWAP; opcode 2 -> param 0 MIN, 1 MAX, 2 MINU, 3 MAXU, 4 ADD (mod 2^TL_DW).
REQ-020 PUT: ma_valid=1, ma_opcode=0, ma_data=result, same address/size; stable until ma_ready; then PWAIT.
REQ-021 PWAIT: md_ready=1; on md_valid go to RESP; md_denied sets denied; md_data ignored.
REQ-022 RESP: d_valid=1, d_data=old value (0 if Get denied), d_source/d_size = registered; stable until d_ready; then IDLE.
REQ-023 md_ready SHALL be 0 outside GWAIT/PWAIT; ma_valid 0 outside GET/PUT; d_valid 0 outside RESP.
REQ-024 Minimum latency with zero-wait memory and ready handshakes: accept at cycle 0, Get cycle 1, Put cycle 3, d_valid cycle 5.

Reset
REQ-025 Reset SHALL force IDLE and clear all registers; a_ready=1, every other output 0, including mid-transaction (in-flight transaction abandoned).
REQ-026 Reset deassertion SHALL be sampled on the clock; first accept is no earlier than the first edge after deassertion.

Structure
REQ-027 Package tl_atomic_pkg SHALL hold opcode constants (Get, PutFullData, AccessAckData, Arithmetic, Logical) and the state enum.
REQ-028 SHALL instantiate exactly one atomalu sub-module; no other sub-modules.

Verification
REQ-029 LogicalData param 0, a_data=0xF0F0F0F0, memory 0x0F0F00FF -> Put data 0xFFFFF00F, d_data 0x0F0F00FF.
REQ-030 ArithmeticData param 0 (MIN), a_data=0xFFFFFFFF, memory 0x00000001 -> Put data 0xFFFFFFFF; param 2 (MINU) -> Put data 0x00000001.
REQ-031 ArithmeticData param 4, a_data=0xFFFFFFFF, memory 0x00000002 -> Put data 0x00000001, d_data 0x00000002.
REQ-032 Get answered with md_denied=1 -> no Put issued, d_denied=1, d_data=0, d_source equals request source.
REQ-033 ma_ready and d_ready held low 3 cycles each -> ma_*/d_* fields stable throughout, a_ready stays 0 until response accepted.
REQ-034 tilelink_reset_i pulsed while in PWAIT -> next cycle all outputs at reset values; a following request completes normally.

Source files
------------

// File: rtl/tl_atomic_pkg.sv
// Shared TileLink opcode/param constants and the atomic sequencer state encoding.
package tl_atomic_pkg;

  localparam logic [2:0] OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] OP_ARITHMETIC      = 3'd2;
  localparam logic [2:0] OP_LOGICAL         = 3'd3;
  localparam logic [2:0] OP_GET             = 3'd4;

  localparam logic [2:0] LOG_XOR  = 3'd0;
  localparam logic [2:0] LOG_OR   = 3'd1;
  localparam logic [2:0] LOG_AND  = 3'd2;
  localparam logic [2:0] LOG_SWAP = 3'd3;

  localparam logic [2:0] ARI_MIN  = 3'd0;
  localparam logic [2:0] ARI_MAX  = 3'd1;
  localparam logic [2:0] ARI_MINU = 3'd2;
  localparam logic [2:0] ARI_MAXU = 3'd3;
  localparam logic [2:0] ARI_ADD  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET,
    ST_GWAIT,
    ST_PUT,
    ST_PWAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/atomic_sequencer_if.sv
// Upstream A/D and memory-side A/D channels of the atomic sequencer.
interface atomic_sequencer_if #(
  parameter int TL_DW = 32,
  parameter int TL_AW = 32,
  parameter int TL_SW = 4
);
  logic             a_valid;
  logic             a_ready;
  logic [2:0]       a_opcode;
  logic [2:0]       a_param;
  logic [2:0]       a_size;
  logic [TL_SW-1:0] a_source;
  logic [TL_AW-1:0] a_address;
  logic [TL_DW-1:0] a_data;

  logic             d_valid;
  logic             d_ready;
  logic [2:0]       d_opcode;
  logic [2:0]       d_size;
  logic [TL_SW-1:0] d_source;
  logic [TL_DW-1:0] d_data;
  logic             d_denied;

  logic             ma_valid;
  logic             ma_ready;
  logic [2:0]       ma_opcode;
  logic [2:0]       ma_size;
  logic [TL_AW-1:0] ma_address;
  logic [TL_DW-1:0] ma_data;

  logic             md_valid;
  logic             md_ready;
  logic [TL_DW-1:0] md_data;
  logic             md_denied;

  // slave is the sequencer's view; master is the requester plus memory around it
  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_data,
    output a_ready,
    output d_valid, d_opcode, d_size, d_source, d_data, d_denied,
    input  d_ready,
    output ma_valid, ma_opcode, ma_size, ma_address, ma_data,
    input  ma_ready,
    input  md_valid, md_data, md_denied,
    output md_ready
  );

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_source, d_data, d_denied,
    output d_ready,
    input  ma_valid, ma_opcode, ma_size, ma_address, ma_data,
    output ma_ready,
    output md_valid, md_data, md_denied,
    input  md_ready
  );
endinterface

// File: rtl/atomalu.sv
// Combinational atomic ALU: combines the request operand with the current memory word.
module atomalu
  import tl_atomic_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    i_opcode,
  input  logic [2:0]    i_param,
  input  logic [DW-1:0] i_operand,
  input  logic [DW-1:0] i_memory,
  output logic [DW-1:0] o_result
);

  logic w_lt_signed;
  logic w_lt_unsigned;

  assign w_lt_signed   = $signed(i_operand) < $signed(i_memory);
  assign w_lt_unsigned = i_operand < i_memory;

  // Unlisted sub-operations leave memory unchanged by writing back the old word
  always_comb begin
    o_result = i_memory;
    if (i_opcode == OP_LOGICAL) begin
      case (i_param)
        LOG_XOR:  o_result = i_operand ^ i_memory;
        LOG_OR:   o_result = i_operand | i_memory;
        LOG_AND:  o_result = i_operand & i_memory;
        LOG_SWAP: o_result = i_operand;
        default:  o_result = i_memory;
      endcase
    end else if (i_opcode == OP_ARITHMETIC) begin
      case (i_param)
        ARI_MIN:  o_result = w_lt_signed   ? i_operand : i_memory;
        ARI_MAX:  o_result = w_lt_signed   ? i_memory  : i_operand;
        ARI_MINU: o_result = w_lt_unsigned ? i_operand : i_memory;
        ARI_MAXU: o_result = w_lt_unsigned ? i_memory  : i_operand;
        ARI_ADD:  o_result = i_operand + i_memory;
        default:  o_result = i_memory;
      endcase
    end
  end

endmodule

// File: rtl/atomic_sequencer.sv
// Turns one TileLink atomic request into a memory Get, an ALU step and a PutFullData,
// then answers upstream with the pre-operation value. One transaction in flight.
module atomic_sequencer
  import tl_atomic_pkg::*;
#(
  parameter int TL_DW = 32,
  parameter int TL_AW = 32,
  parameter int TL_SW = 4
) (
  input logic               tilelink_clock_i,
  input logic               tilelink_reset_i,
  atomic_sequencer_if.slave bus
);

  state_e           r_state;
  state_e           w_next_state;

  logic [2:0]       r_opcode;
  logic [2:0]       r_param;
  logic [2:0]       r_size;
  logic [TL_SW-1:0] r_source;
  logic [TL_AW-1:0] r_address;
  logic [TL_DW-1:0] r_data;
  logic [TL_DW-1:0] r_old;
  logic [TL_DW-1:0] r_result;
  logic             r_denied;

  logic [TL_DW-1:0] w_result;
  logic             w_a_ready;
  logic             w_ma_valid;
  logic [2:0]       w_ma_opcode;
  logic [TL_DW-1:0] w_ma_data;
  logic             w_md_ready;
  logic             w_d_valid;
  logic [2:0]       w_d_opcode;

  atomalu #(.DW(TL_DW)) u_atomalu (
    .i_opcode  (r_opcode),
    .i_param   (r_param),
    .i_operand (r_data),
    .i_memory  (bus.md_data),
    .o_result  (w_result)
  );

  always_ff @(posedge tilelink_clock_i or posedge tilelink_reset_i) begin
    if (tilelink_reset_i) r_state <= ST_IDLE;
    else                  r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (bus.a_valid)  w_next_state = ST_GET;
      ST_GET:   if (bus.ma_ready) w_next_state = ST_GWAIT;
      ST_GWAIT: if (bus.md_valid) w_next_state = bus.md_denied ? ST_RESP : ST_PUT;
      ST_PUT:   if (bus.ma_ready) w_next_state = ST_PWAIT;
      ST_PWAIT: if (bus.md_valid) w_next_state = ST_RESP;
      ST_RESP:  if (bus.d_ready)  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_a_ready   = 1'b0;
    w_ma_valid  = 1'b0;
    w_ma_opcode = OP_PUT_FULL;
    w_ma_data   = '0;
    w_md_ready  = 1'b0;
    w_d_valid   = 1'b0;
    w_d_opcode  = '0;
    case (r_state)
      ST_IDLE:  w_a_ready = 1'b1;
      ST_GET: begin
        w_ma_valid  = 1'b1;
        w_ma_opcode = OP_GET;
      end
      ST_PUT: begin
        w_ma_valid = 1'b1;
        w_ma_data  = r_result;
      end
      ST_GWAIT, ST_PWAIT: w_md_ready = 1'b1;
      ST_RESP: begin
        w_d_valid  = 1'b1;
        w_d_opcode = OP_ACCESS_ACK_DATA;
      end
      default: ;
    endcase
  end

  // A denied Get reports zero as the old value; a denied Put keeps the old value
  always_ff @(posedge tilelink_clock_i or posedge tilelink_reset_i) begin
    if (tilelink_reset_i) begin
      r_opcode  <= '0;
      r_param   <= '0;
      r_size    <= '0;
      r_source  <= '0;
      r_address <= '0;
      r_data    <= '0;
      r_old     <= '0;
      r_result  <= '0;
      r_denied  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.a_valid) begin
            r_opcode  <= bus.a_opcode;
            r_param   <= bus.a_param;
            r_size    <= bus.a_size;
            r_source  <= bus.a_source;
            r_address <= bus.a_address;
            r_data    <= bus.a_data;
            r_old     <= '0;
            r_result  <= '0;
            r_denied  <= 1'b0;
          end
        end
        ST_GWAIT: begin
          if (bus.md_valid) begin
            if (bus.md_denied) begin
              r_denied <= 1'b1;
              r_old    <= '0;
            end else begin
              r_old    <= bus.md_data;
              r_result <= w_result;
            end
          end
        end
        ST_PWAIT: begin
          if (bus.md_valid && bus.md_denied) r_denied <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.a_ready    = w_a_ready;
  assign bus.ma_valid   = w_ma_valid;
  assign bus.ma_opcode  = w_ma_opcode;
  assign bus.ma_size    = r_size;
  assign bus.ma_address = r_address;
  assign bus.ma_data    = w_ma_data;
  assign bus.md_ready   = w_md_ready;
  assign bus.d_valid    = w_d_valid;
  assign bus.d_opcode   = w_d_opcode;
  assign bus.d_size     = r_size;
  assign bus.d_source   = r_source;
  assign bus.d_data     = r_old;
  assign bus.d_denied   = r_denied;

endmodule

// File: tb/tb_atomic_sequencer.sv
// Self-checking bench: plays requester and memory around atomic_sequencer,
// predicting every response from a word-level memory model.
module tb_atomic_sequencer;

  logic clk;
  logic rst;
  int   cycleCount;
  int   nCompared;
  int   nMismatched;

  logic [31:0] mem [logic [31:0]];

  atomic_sequencer_if #(.TL_DW(32), .TL_AW(32), .TL_SW(4)) bus ();

  atomic_sequencer #(.TL_DW(32), .TL_AW(32), .TL_SW(4)) dut (
    .tilelink_clock_i (clk),
    .tilelink_reset_i (rst),
    .bus              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic getFlag(input int which);
    case (which)
      0:       return bus.ma_valid;
      1:       return bus.md_ready;
      2:       return bus.d_valid;
      default: return bus.a_ready;
    endcase
  endfunction

  task automatic waitFlag(input int which, input string tag);
    int k = 0;
    while (getFlag(which) !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, 64'(getFlag(which)), 64'd1);
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] addr);
    if (!mem.exists(addr)) mem[addr] = $urandom;
    return mem[addr];
  endfunction

  // Reference semantics computed with wide integer arithmetic
  function automatic logic [31:0] refAtomic(input logic [2:0] op, input logic [2:0] p,
                                           input logic [31:0] a, input logic [31:0] m);
    longint ua = longint'(a);
    longint um = longint'(m);
    longint sa = a[31] ? ua - 64'sd4294967296 : ua;
    longint sm = m[31] ? um - 64'sd4294967296 : um;
    if (op == 3'd3) begin
      case (p)
        3'd0:    return a ^ m;
        3'd1:    return a | m;
        3'd2:    return a & m;
        3'd3:    return a;
        default: return m;
      endcase
    end
    case (p)
      3'd0:    return (sa <= sm) ? a : m;
      3'd1:    return (sa >= sm) ? a : m;
      3'd2:    return (ua <= um) ? a : m;
      3'd3:    return (ua >= um) ? a : m;
      3'd4:    return 32'((ua + um) % 64'sd4294967296);
      default: return m;
    endcase
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ctl"},
                64'({bus.a_ready, bus.d_valid, bus.ma_valid, bus.md_ready, bus.d_denied}),
                64'b10000);
    checkOutput({tag, "_hdr"},
                64'({bus.ma_opcode, bus.d_opcode, bus.d_size, bus.ma_size, bus.d_source}), 64'd0);
    checkOutput({tag, "_ddata"}, 64'(bus.d_data), 64'd0);
    checkOutput({tag, "_mabus"}, {bus.ma_address, bus.ma_data}, 64'd0);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] param,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] src, input bit memDeny, input bit putDeny,
                               input int maStall, input int dStall, input int memDelay,
                               input bit checkLat, input bit resetInPwait);
    logic [31:0] oldVal;
    logic [31:0] expPut;
    int          startCycle;
    oldVal = memRead(addr);
    expPut = refAtomic(op, param, data, oldVal);

    waitFlag(3, "a_ready_idle");
    bus.a_valid   = 1'b1;
    bus.a_opcode  = op;
    bus.a_param   = param;
    bus.a_source  = src;
    bus.a_address = addr;
    bus.a_data    = data;
    startCycle    = cycleCount;
    @(negedge clk);
    bus.a_valid = 1'b0;
    bus.a_data  = $urandom;

    waitFlag(0, "get_valid");
    if (checkLat) checkOutput("get_latency", 64'(cycleCount - startCycle), 64'd1);
    for (int s = 0; s <= maStall; s++) begin
      checkOutput("get_fields", {bus.ma_valid, bus.ma_opcode, bus.ma_size, bus.ma_address},
                  {57'b0, 1'b1, 3'd4, 3'd2} << 32 | 64'(addr));
      checkOutput("get_data", 64'(bus.ma_data), 64'd0);
      checkOutput("get_a_ready", 64'(bus.a_ready), 64'd0);
      if (s < maStall) @(negedge clk);
    end
    bus.ma_ready = 1'b1;
    @(negedge clk);
    bus.ma_ready = 1'b0;

    waitFlag(1, "gwait_md_ready");
    repeat (memDelay) begin
      @(negedge clk);
      checkOutput("gwait_hold", 64'({bus.md_ready, bus.ma_valid, bus.d_valid}), 64'b100);
    end
    bus.md_valid  = 1'b1;
    bus.md_data   = oldVal;
    bus.md_denied = memDeny;
    @(negedge clk);
    bus.md_valid  = 1'b0;
    bus.md_denied = 1'b0;
    bus.md_data   = '0;

    if (memDeny) begin
      checkOutput("no_put_after_deny", 64'(bus.ma_valid), 64'd0);
    end else begin
      waitFlag(0, "put_valid");
      if (checkLat) checkOutput("put_latency", 64'(cycleCount - startCycle), 64'd3);
      for (int s = 0; s <= maStall; s++) begin
        checkOutput("put_fields", {bus.ma_valid, bus.ma_opcode, bus.ma_size, bus.ma_address},
                    {57'b0, 1'b1, 3'd0, 3'd2} << 32 | 64'(addr));
        checkOutput("put_data", 64'(bus.ma_data), 64'(expPut));
        checkOutput("put_a_ready", 64'(bus.a_ready), 64'd0);
        if (s < maStall) @(negedge clk);
      end
      bus.ma_ready = 1'b1;
      @(negedge clk);
      bus.ma_ready = 1'b0;
      mem[addr] = expPut;

      waitFlag(1, "pwait_md_ready");
      if (resetInPwait) begin
        rst = 1'b1;
        #1;
        checkResetState("reset_in_pwait");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkResetState("after_pwait_reset");
        return;
      end
      bus.md_valid  = 1'b1;
      bus.md_data   = $urandom;
      bus.md_denied = putDeny;
      @(negedge clk);
      bus.md_valid  = 1'b0;
      bus.md_denied = 1'b0;
    end

    waitFlag(2, "d_valid");
    if (checkLat) checkOutput("resp_latency", 64'(cycleCount - startCycle), 64'd5);
    for (int s = 0; s <= dStall; s++) begin
      checkOutput("resp_hdr", 64'({bus.d_opcode, bus.d_size, bus.d_source, bus.d_denied}),
                  64'({3'd1, 3'd2, src, memDeny | putDeny}));
      checkOutput("resp_data", 64'(bus.d_data), memDeny ? 64'd0 : 64'(oldVal));
      checkOutput("resp_quiet", 64'({bus.a_ready, bus.ma_valid, bus.md_ready}), 64'd0);
      if (s < dStall) @(negedge clk);
    end
    bus.d_ready = 1'b1;
    @(negedge clk);
    bus.d_ready = 1'b0;
    checkOutput("back_to_idle", 64'({bus.a_ready, bus.d_valid}), 64'b10);
  endtask

  initial begin
    logic [2:0]  op;
    logic [2:0]  param;
    logic [31:0] data;
    nCompared   = 0;
    nMismatched = 0;
    cycleCount  = 0;
    rst           = 1'b1;
    bus.a_valid   = 1'b0;
    bus.a_opcode  = 3'd3;
    bus.a_param   = 3'd0;
    bus.a_size    = 3'd2;
    bus.a_source  = '0;
    bus.a_address = '0;
    bus.a_data    = '0;
    bus.d_ready   = 1'b0;
    bus.ma_ready  = 1'b0;
    bus.md_valid  = 1'b0;
    bus.md_data   = '0;
    bus.md_denied = 1'b0;

    repeat (2) @(negedge clk);
    checkResetState("reset_hold");
    rst = 1'b0;
    @(negedge clk);
    checkResetState("after_deassert");

    mem[32'h40] = 32'h0F0F00FF;
    applyStimulus(3'd3, 3'd0, 32'h40, 32'hF0F0F0F0, 4'h5, 0, 0, 0, 0, 0, 1, 0);
    mem[32'h44] = 32'h00000001;
    applyStimulus(3'd2, 3'd0, 32'h44, 32'hFFFFFFFF, 4'h1, 0, 0, 0, 0, 0, 1, 0);
    mem[32'h48] = 32'h00000001;
    applyStimulus(3'd2, 3'd2, 32'h48, 32'hFFFFFFFF, 4'h2, 0, 0, 0, 0, 0, 1, 0);
    mem[32'h4C] = 32'h00000002;
    applyStimulus(3'd2, 3'd4, 32'h4C, 32'hFFFFFFFF, 4'h3, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(3'd3, 3'd1, 32'h50, 32'h12345678, 4'hA, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(2'd2, 3'd1, 32'h54, 32'h80000000, 4'h7, 0, 0, 3, 3, 2, 0, 0);
    applyStimulus(3'd3, 3'd2, 32'h58, 32'hA5A5A5A5, 4'hC, 0, 1, 0, 1, 0, 0, 0);
    applyStimulus(3'd3, 3'd3, 32'h5C, 32'hCAFEF00D, 4'h9, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(3'd2, 3'd4, 32'h5C, 32'h00000003, 4'h6, 0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 24; i++) begin
      op    = 3'($urandom_range(2, 3));
      param = (op == 3'd3) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 4));
      case ($urandom_range(0, 3))
        0:       data = 32'h0;
        1:       data = 32'hFFFFFFFF;
        2:       data = 32'h80000000;
        default: data = $urandom;
      endcase
      applyStimulus(op, param, 32'h1000 + 32'($urandom_range(0, 3) * 4), data,
                    4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
